// File: rtl/systolic_result_writer.sv
// systolic_result_writer
//   Write-back unit for the systolic NxN array. On start it snapshots the
//   array's N x N result matrix and the base address. It then writes the
//   matrix row-major into a result SRAM, one sign-extended DATA_W word per
//   granted cycle. When the last word is written it pulses done and
//   acc_clear for one cycle.
//
// Ports
//   clk        in   clock; all state updates on the rising edge
//   rst_n      in   synchronous active-low reset
//   start      in   one-cycle request to capture and write out res
//   base_addr  in   first SRAM word address, sampled with start
//   res        in   array results, res[r][c] = row r, column c, sampled with start
//   gnt        in   SRAM write port granted this cycle
//   busy       out  transfer in progress (WRITE or FIN)
//   done       out  one-cycle pulse after the last write
//   acc_clear  out  one-cycle pulse with done, clears the array
//   wsbn       out  SRAM write strobe, active-low
//   waddr      out  SRAM write address (base + idx, wraps mod 2^ADDR_W)
//   wdata      out  SRAM write data (sign-extended result element)
module systolic_result_writer #(
    parameter int N      = 4,
    parameter int OUT_W  = 20,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 13
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [ADDR_W-1:0]                   base_addr,
    input  logic [N-1:0][N-1:0][OUT_W-1:0]      res,
    input  logic                                gnt,
    output logic                                busy,
    output logic                                done,
    output logic                                acc_clear,
    output logic                                wsbn,
    output logic [ADDR_W-1:0]                   waddr,
    output logic [DATA_W-1:0]                   wdata
);

    localparam int IDX_W = (N * N > 1) ? $clog2(N * N) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N * N - 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        FIN
    } state_t;

    state_t                         state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [ADDR_W-1:0]              base_q, base_d;
    // Flattened row-major copy of res: snap[r*N + c] = res[r][c].
    logic [N*N-1:0][OUT_W-1:0]      snap_q, snap_d;
    logic [OUT_W-1:0]               elem;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        snap_d  = snap_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d  = res;
                    base_d  = base_addr;
                    idx_d   = '0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (gnt) begin
                    if (idx_q == LAST) begin
                        idx_d   = '0;
                        state_d = FIN;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            FIN: begin
                idx_d   = '0;
                state_d = IDLE;
            end
            default: begin
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            base_q  <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            snap_q  <= snap_d;
        end
    end

    always_comb begin
        elem      = snap_q[idx_q];
        busy      = (state_q != IDLE);
        done      = (state_q == FIN);
        acc_clear = (state_q == FIN);
        // The strobe follows gnt combinationally so a granted cycle is a write cycle.
        wsbn      = !((state_q == WRITE) && gnt);
        waddr     = base_q + ADDR_W'(idx_q);
        wdata     = DATA_W'($signed(elem));
    end

endmodule
